// File: rtl/uart_tx_frame_engine.sv
// uart_tx_frame_engine: UART transmit frame FSM with runtime data width,
// parity, stop count and bit order, paced by an external baud tick.
module uart_tx_frame_engine #(
    parameter int DATA_W   = 8,
    parameter int FIFO_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_BaudSig_i,
    input  logic              p_TxEn_i,
    input  logic [3:0]        DataBits_i,
    input  logic [2:0]        ParityMode_i,
    input  logic              StopBits_i,
    input  logic              p_BigEnd_i,
    output logic              n_FifoRe_o,
    input  logic [DATA_W-1:0] FifoData_i,
    input  logic              p_FiFoEmpty_i,
    output logic [4:0]        State_o,
    output logic [3:0]        BitCounter_o,
    output logic [DATA_W-1:0] ShiftData_o,
    output logic              SerialData_o,
    output logic              p_Busy_o,
    output logic              p_FrameDone_o
);

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_START  = 5'b00010,
        S_DATA   = 5'b00100,
        S_PARITY = 5'b01000,
        S_STOP   = 5'b10000
    } state_t;

    localparam logic [3:0] MAX_BITS = 4'(DATA_W);

    state_t              r_state;
    logic [3:0]          r_bitCnt;
    logic [3:0]          r_bits;
    logic [2:0]          r_parMode;
    logic                r_stop2;
    logic                r_bigEnd;
    logic                r_stopCnt;
    logic [DATA_W-1:0]   r_shift;
    logic                r_parBit;
    logic                r_serial;
    logic                r_nRe;
    logic                r_busy;
    logic                r_done;
    logic [FIFO_LAT-1:0] r_rdPipe;

    logic [3:0]          w_bitsClamp;
    logic [2:0]          w_parMode;
    logic [DATA_W-1:0]   w_mask;
    logic [DATA_W-1:0]   w_capData;
    logic                w_capPar;
    logic [3:0]          w_bitIdx;
    logic                w_dataBit;
    logic                w_lastBit;
    logic                w_stopEnd;
    logic                w_launch;
    logic                w_line;

    always_comb begin
        if (DataBits_i < 4'd5)
            w_bitsClamp = 4'd5;
        else if (DataBits_i > MAX_BITS)
            w_bitsClamp = MAX_BITS;
        else
            w_bitsClamp = DataBits_i;
    end

    assign w_parMode = (ParityMode_i >= 3'd1 && ParityMode_i <= 3'd4) ?
                       ParityMode_i : 3'd0;

    // Capture uses the frozen frame width, never the live input.
    assign w_mask    = ~({DATA_W{1'b1}} << r_bits);
    assign w_capData = FifoData_i & w_mask;

    always_comb begin
        case (r_parMode)
            3'd1:    w_capPar = ~^w_capData;
            3'd2:    w_capPar = ^w_capData;
            3'd3:    w_capPar = 1'b1;
            default: w_capPar = 1'b0;
        endcase
    end

    assign w_bitIdx = r_bigEnd ? (r_bits - 4'd1 - r_bitCnt) : r_bitCnt;

    always_comb begin
        w_dataBit = 1'b0;
        for (int i = 0; i < DATA_W; i++)
            if (w_bitIdx == 4'(i))
                w_dataBit = r_shift[i];
    end

    assign w_lastBit = (r_bitCnt == r_bits - 4'd1);
    assign w_stopEnd = !(r_stop2 && !r_stopCnt);
    assign w_launch  = p_BaudSig_i && p_TxEn_i && !p_FiFoEmpty_i &&
                       (r_state == S_IDLE ||
                        (r_state == S_STOP && w_stopEnd));

    always_comb begin
        case (r_state)
            S_START:  w_line = 1'b0;
            S_DATA:   w_line = w_dataBit;
            S_PARITY: w_line = r_parBit;
            default:  w_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bitCnt  <= 4'd0;
            r_bits    <= 4'd5;
            r_parMode <= 3'd0;
            r_stop2   <= 1'b0;
            r_bigEnd  <= 1'b0;
            r_stopCnt <= 1'b0;
            r_shift   <= '0;
            r_parBit  <= 1'b0;
            r_serial  <= 1'b1;
            r_nRe     <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rdPipe  <= '0;
        end else begin
            r_nRe    <= 1'b1;
            r_done   <= 1'b0;
            r_serial <= w_line;
            r_rdPipe <= FIFO_LAT'({r_rdPipe, ~r_nRe});
            if (r_rdPipe[FIFO_LAT-1]) begin
                r_shift  <= w_capData;
                r_parBit <= w_capPar;
            end
            if (w_launch) begin
                r_nRe     <= 1'b0;
                r_bits    <= w_bitsClamp;
                r_parMode <= w_parMode;
                r_stop2   <= StopBits_i;
                r_bigEnd  <= p_BigEnd_i;
            end
            if (p_BaudSig_i) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_launch) begin
                            r_state <= S_START;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_START: begin
                        r_state  <= S_DATA;
                        r_bitCnt <= 4'd0;
                    end
                    S_DATA: begin
                        if (w_lastBit) begin
                            r_bitCnt  <= 4'd0;
                            r_stopCnt <= 1'b0;
                            r_state   <= (r_parMode != 3'd0) ?
                                         S_PARITY : S_STOP;
                        end else begin
                            r_bitCnt <= r_bitCnt + 4'd1;
                        end
                    end
                    S_PARITY: begin
                        r_state   <= S_STOP;
                        r_stopCnt <= 1'b0;
                    end
                    S_STOP: begin
                        if (!w_stopEnd) begin
                            r_stopCnt <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                            if (w_launch) begin
                                r_state <= S_START;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign State_o       = r_state;
    assign BitCounter_o  = r_bitCnt;
    assign ShiftData_o   = r_shift;
    assign SerialData_o  = r_serial;
    assign n_FifoRe_o    = r_nRe;
    assign p_Busy_o      = r_busy;
    assign p_FrameDone_o = r_done;

endmodule
